// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Bus widths, the zero/NOP words and the queue entry layout live here.
package inst_fetch_queue_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] inst_addr_t;

  localparam inst_t      NOP_INST  = 32'h0000_0000;
  localparam inst_addr_t ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    logic       alloc;
    logic       filled;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction-memory request/grant + in-order response bus.
// The fetch queue is the master; the instruction memory is the slave.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic       imem_req;
  inst_addr_t imem_addr;
  logic       imem_gnt;
  logic       imem_rvalid;
  inst_t      imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues word reads for the current PC, buffers in-order
// responses with their PCs and hands them to decode over valid/ready.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  inst_addr_t           pc_i,
  input  logic                 ce_i,
  input  logic                 flush_i,
  output logic                 stallreq_o,
  inst_fetch_queue_if.master   imem,
  output logic                 id_valid_o,
  output inst_addr_t           id_pc_o,
  output inst_t                id_inst_o,
  input  logic                 id_ready_i
);

  ifq_entry_t    ent_q [DEPTH];
  logic [AW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [AW:0]   used_cnt, drop_cnt, pend_cnt;
  logic [AW+1:0] credit;
  logic          issue, pop, rsp_drop, rsp_fill, rsp_hit;

  // Credits cover both live entries and responses still owed to flushed fetches.
  assign credit         = {1'b0, used_cnt} + {1'b0, drop_cnt};
  assign imem.imem_req  = ce_i & ~flush_i & (credit < (AW+2)'(DEPTH));
  assign imem.imem_addr = pc_i;
  assign issue          = imem.imem_req & imem.imem_gnt;
  assign stallreq_o     = ce_i & ~flush_i & ~issue;

  assign rsp_drop = imem.imem_rvalid & (drop_cnt != '0);
  assign rsp_fill = imem.imem_rvalid & (drop_cnt == '0)
                  & ent_q[fill_ptr].alloc & ~ent_q[fill_ptr].filled;
  assign rsp_hit  = rsp_drop | rsp_fill;

  assign id_valid_o = ent_q[head_ptr].alloc & ent_q[head_ptr].filled;
  assign id_pc_o    = id_valid_o ? ent_q[head_ptr].pc   : ZERO_WORD;
  assign id_inst_o  = id_valid_o ? ent_q[head_ptr].inst : NOP_INST;
  assign pop        = id_valid_o & id_ready_i;

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      pend_cnt = pend_cnt + (AW+1)'(ent_q[i].alloc & ~ent_q[i].filled);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used_cnt  <= '0;
      drop_cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i].alloc  <= 1'b0;
        ent_q[i].filled <= 1'b0;
      end
    end else if (flush_i) begin
      // Every outstanding fetch becomes a drop, less the response consumed this cycle.
      drop_cnt  <= drop_cnt + pend_cnt - (AW+1)'(rsp_hit);
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used_cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i].alloc  <= 1'b0;
        ent_q[i].filled <= 1'b0;
      end
    end else begin
      if (issue) begin
        ent_q[alloc_ptr].pc     <= pc_i;
        ent_q[alloc_ptr].alloc  <= 1'b1;
        ent_q[alloc_ptr].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + AW'(1);
      end
      if (rsp_drop)
        drop_cnt <= drop_cnt - (AW+1)'(1);
      if (rsp_fill) begin
        ent_q[fill_ptr].inst   <= imem.imem_rdata;
        ent_q[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + AW'(1);
      end
      if (pop) begin
        ent_q[head_ptr].alloc <= 1'b0;
        head_ptr              <= head_ptr + AW'(1);
      end
      used_cnt <= used_cnt + (AW+1)'(issue) - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: behavioural memory with per-request latency
// and a scoreboard of issued fetches compared as decode consumes them.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  inst_addr_t pc_i;
  logic       ce_i, flush_i, stallreq_o, id_valid_o, id_ready_i;
  inst_addr_t id_pc_o;
  inst_t      id_inst_o;

  inst_fetch_queue_if bus ();

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .imem       (bus),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_ready_i (id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit filled; } sb_t;
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;

  sb_t  sb [$];
  req_t pend [$];

  int unsigned total = 0, bad = 0, cyc = 0, issued_n = 0, resp_n = 0;
  logic [31:0] pc;
  bit do_rst, ce, flush, gnt, ready;
  int unsigned lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check combinational/registered outputs,
  // then advance the model to what the coming posedge should do.
  task automatic step();
    bit          rv, exp_req, exp_valid, issue;
    int unsigned stale_n;
    logic [31:0] exp_pc, exp_inst;
    req_t        r;
    @(negedge clk);
    rst = do_rst; pc_i = pc; ce_i = ce; flush_i = flush;
    id_ready_i = ready; bus.imem_gnt = gnt;
    rv = !do_rst && pend.size() > 0 && pend[0].due <= cyc;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
    if (rv) assert (resp_n < issued_n) else $error("rvalid without outstanding request");
    #1;
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    exp_req   = ce && !flush && (sb.size() + stale_n < DEPTH);
    issue     = exp_req && gnt;
    exp_valid = sb.size() > 0 && sb[0].filled;
    exp_pc    = exp_valid ? sb[0].pc : 32'h0;
    exp_inst  = exp_valid ? mem_word(sb[0].pc) : 32'h0;
    chk("imem_req",  {31'b0, bus.imem_req}, {31'b0, exp_req});
    chk("imem_addr", bus.imem_addr, pc);
    chk("stallreq",  {31'b0, stallreq_o}, {31'b0, ce && !flush && !issue});
    chk("id_valid",  {31'b0, id_valid_o}, {31'b0, exp_valid});
    chk("id_pc",     id_pc_o, exp_pc);
    chk("id_inst",   id_inst_o, exp_inst);
    if (do_rst) begin
      sb.delete(); pend.delete(); issued_n = 0; resp_n = 0;
    end else begin
      if (exp_valid && ready) void'(sb.pop_front());
      if (rv) begin
        resp_n++;
        r = pend.pop_front();
        if (!r.stale)
          for (int i = 0; i < sb.size(); i++)
            if (!sb[i].filled) begin sb[i].filled = 1'b1; break; end
      end
      if (issue) begin
        sb.push_back('{pc, 1'b0});
        pend.push_back('{pc, cyc + lat, 1'b0});
        issued_n++;
        pc = pc + 32'd4;
      end
      if (flush) begin
        sb.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; ce_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    do_rst = 1; ce = 0; flush = 0; gnt = 0; ready = 0; pc = 32'h0; lat = 1;
    repeat (3) step();
    do_rst = 0;

    // Sequential fetches 0x0,0x4,0x8,0xc with single-cycle memory.
    ce = 1; gnt = 1; ready = 1;
    repeat (4) step();
    // Grant withheld three cycles at 0x10.
    gnt = 0;
    repeat (3) step();
    gnt = 1;
    repeat (3) step();

    // Decode stalled: queue fills, then one pop frees a slot.
    ready = 0;
    repeat (7) step();
    ready = 1; step();
    ready = 0; repeat (3) step();
    ready = 1; ce = 0; repeat (6) step();

    // Three fetches in flight at L=3, flushed, then redirect to 0x100.
    lat = 3; ce = 1; gnt = 1; ready = 1;
    repeat (3) step();
    flush = 1; step();
    flush = 0; pc = 32'h100;
    repeat (12) step();

    // Flush while responses and pops are streaming every cycle.
    lat = 1;
    repeat (4) step();
    flush = 1; step();
    flush = 0; pc = 32'h200;
    repeat (8) step();

    // Random grant/ready/latency with occasional redirects.
    for (int n = 0; n < 80; n++) begin
      gnt   = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      lat   = $urandom_range(1, 3);
      flush = ($urandom_range(0, 19) == 0);
      step();
      if (flush) begin
        flush = 0;
        pc = 32'($urandom_range(0, 1023)) << 2;
      end
    end

    // Drain everything still queued or in flight.
    ce = 0; gnt = 0; ready = 1; flush = 0;
    for (int n = 0; n < 40 && (sb.size() > 0 || pend.size() > 0); n++) step();
    chk("drain_sb",   32'(sb.size()), 32'd0);
    chk("drain_pend", 32'(pend.size()), 32'd0);
    chk("issued_any", {31'b0, issued_n > 20}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction-fetch stage directly downstream of the PC register. It takes the current fetch PC and chip-enable, issues word-read requests to the instruction memory over a request/grant and response-valid handshake, and reorders nothing: responses return in order. It buffers up to DEPTH in-flight or returned instructions with their PCs and presents them to the IF/ID boundary through a valid/ready interface. It raises a stall request to the pipeline controller whenever the current PC cannot be issued, so the PC register holds.

Parameters:
DEPTH, 4, number of entries (allocated + in-flight), power of 2, >=2
AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc_i  in  32  fetch PC from PC register
ce_i  in  1  fetch enable from PC register (0 = no fetch)
flush_i  in  1  branch/exception flush; discards all queued and in-flight fetches
stallreq_o  out  1  to controller; 1 = current pc_i not accepted this cycle
imem_req_o  out  1  memory read request
imem_addr_o  out  32  word address = pc_i
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  read data valid (in issue order)
imem_rdata_i  in  32  read data
id_valid_o  out  1  head entry holds an instruction
id_pc_o  out  32  PC of head entry
id_inst_o  out  32  instruction of head entry
id_ready_i  in  1  decode consumes head this cycle

Behaviour:
- Storage: DEPTH entries {pc, inst, alloc, filled}; alloc_ptr, fill_ptr, head_ptr (AW bits, wrap modulo DEPTH); used_cnt (AW+1 bits) = allocated entries; drop_cnt (AW+1 bits) = in-flight responses to discard.
- Issue: imem_req_o = ce_i & ~flush_i & (used_cnt + drop_cnt < DEPTH); imem_addr_o = pc_i (combinational). Issue occurs when imem_req_o & imem_gnt_i: entry[alloc_ptr] gets pc=pc_i, alloc=1, filled=0; alloc_ptr++.
- stallreq_o = ce_i & ~(imem_req_o & imem_gnt_i). With ce_i=0, stallreq_o=0. During flush_i, stallreq_o=0 (controller redirects PC).
- Response: when imem_rvalid_i: if drop_cnt!=0, discard data, drop_cnt--; else entry[fill_ptr].inst=imem_rdata_i, filled=1, fill_ptr++. rvalid with no outstanding request is a protocol error: ignored, flagged by bench assertion.
- Output: id_valid_o = alloc & filled of entry[head_ptr]; id_pc_o/id_inst_o from that entry when valid, else 32'h0 (NOP). Pop when id_valid_o & id_ready_i: alloc cleared, head_ptr++.
- Latency: issue in cycle T, rvalid in T+L (L>=1) -> id_valid_o in T+L+1. No response-to-output bypass. Back-to-back issue every cycle when credits and grant allow.
- Simultaneous issue, response and pop in one cycle all take effect; used_cnt += issue - pop.
- Full: used_cnt+drop_cnt==DEPTH -> imem_req_o=0, stallreq_o=1 (if ce_i); a pop in the same cycle frees credit only from next cycle.
- Flush (wins over issue/pop same cycle): drop_cnt <= drop_cnt + (allocated-but-unfilled count) - (1 if rvalid that cycle consumed a drop) adjusted so a response arriving in the flush cycle is also discarded; all alloc/filled cleared; head_ptr=alloc_ptr=fill_ptr=0; used_cnt=0; id_valid_o=0 next cycle.
- Reset: all pointers, counters, alloc/filled bits = 0; outputs: imem_req_o=0 only via ce_i (PC register holds ce low in reset), stallreq_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0. Reset mid-transaction abandons in-flight responses; memory is reset together with the core, so no drop tracking is required across reset.

Decomposition:
- Shared defines file: `InstBus (31:0), `InstAddrBus (31:0), `ZeroWord, `NopInst, `RstEnable, `ChipEnable/`ChipDisable, `Stop/`NoStop.
- Single flat module; storage array and pointer logic in-line. No sub-module warranted.

Test Plan:
- Reset then ce_i=1, pc 0x0,0x4,0x8, gnt=1, L=1, id_ready=1 -> id_valid_o from cycle 3, id_pc 0x0,0x4,0x8 with matching rdata, stallreq_o=0 throughout.
- gnt=0 for 3 cycles at pc 0x10 -> stallreq_o=1 those cycles, imem_addr_o held 0x10, single entry allocated on grant.
- id_ready=0, L=1, DEPTH=4 -> after 4 issues imem_req_o=0, stallreq_o=1; one pop -> issue resumes next cycle at held PC.
- L=3, 3 in flight, flush_i pulse, then new pc 0x100 -> 3 old responses dropped, first id_valid_o shows pc 0x100 with its rdata.
- Flush coincident with rvalid and pop -> that response dropped, id_valid_o=0 next cycle, drop_cnt correct (no stale instruction ever appears).
- Wrap-around: 10 sequential fetches, random gnt/ready, L in 1..3 -> outputs in-order, PC/inst pairs match memory model, no loss/duplication.
